// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, fault word and FIFO entry layout for the fetch front end.
package fetch_unit_pkg;
    localparam int FETCH_INST_W = 32;
    localparam int FETCH_PC_W = 32;
    localparam logic [FETCH_INST_W-1:0] FAULT_INST = 32'h0;
    // Entry packing order is {pc, inst}.
    typedef struct packed {
        logic [FETCH_PC_W-1:0]   pc;
        logic [FETCH_INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry PC-tagged instruction FIFO with flush (flush beats push).
// Ports: i_clk, i_rst_n (async active-low); i_push/i_entry write; i_pop advances head;
//        i_flush empties; o_head is the head entry; o_count is the occupancy.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  fetch_entry_t           i_entry,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (i_flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (i_push) wr_q <= wr_q + 1'b1;
            if (i_pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(i_push) - CW'(i_pop);
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) mem_q[wr_q] <= i_entry;
    end

    assign o_head  = mem_q[rd_q];
    assign o_count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction fetch with credit-limited requests, prefetch FIFO and redirect flush.
// Ports: i_clk, i_rst_n (async active-low); o_mem_req_* / i_mem_req_ready request channel;
//        i_mem_rsp_* in-order response channel; i_redirect_* new fetch PC;
//        o_inst_* / i_inst_ready decode channel with o_inst_fault for misaligned PCs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_req_addr,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_fault
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d, drop_q, drop_d, count;
    logic          fault_q, fault_d;
    logic          req_fire, rsp_keep, pop;
    logic [CW:0]   credit_used;
    fetch_entry_t  head, entry;

    // One extra bit: FIFO occupancy plus in-flight count can reach 2*DEPTH transiently in width terms.
    assign credit_used     = (CW+1)'(count) + (CW+1)'(outstanding_q);
    assign o_mem_req_valid = i_rst_n && !fault_q && !i_redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign o_mem_req_addr  = fetch_pc_q;
    assign req_fire        = o_mem_req_valid && i_mem_req_ready;
    assign rsp_keep        = i_mem_rsp_valid && drop_q == '0 && !i_redirect_valid;
    assign o_inst_valid    = fault_q || count != '0;
    assign pop             = o_inst_valid && i_inst_ready && !fault_q && !i_redirect_valid;
    assign o_inst          = fault_q ? FAULT_INST : head.inst;
    // While faulting, fetch_pc holds the misaligned redirect target since no requests issue.
    assign o_inst_pc       = fault_q ? fetch_pc_q : head.pc;
    assign o_inst_fault    = fault_q;
    assign entry           = '{pc: rsp_pc_q, inst: i_mem_rsp_data};

    always_comb begin
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(i_mem_rsp_valid);
        drop_d        = (i_mem_rsp_valid && drop_q != '0) ? drop_q - 1'b1 : drop_q;
        fetch_pc_d    = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rsp_pc_d      = rsp_keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
        fault_d       = fault_q;
        if (i_redirect_valid) begin
            // Every response still in flight after this cycle belongs to the old stream.
            drop_d     = outstanding_q - CW'(i_mem_rsp_valid);
            fetch_pc_d = i_redirect_pc;
            rsp_pc_d   = i_redirect_pc;
            fault_d    = i_redirect_pc[1:0] != 2'b00;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q    <= RESET_ADDR;
            rsp_pc_q      <= RESET_ADDR;
            outstanding_q <= '0;
            drop_q        <= '0;
            fault_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            fault_q       <= fault_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (rsp_keep),
        .i_entry (entry),
        .i_pop   (pop),
        .i_flush (i_redirect_valid),
        .o_head  (head),
        .o_count (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch_unit bench against a transaction-level queue model.
module tb_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RA    = 32'h0000_0000;

    logic        clk, rst_n;
    logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [31:0] mem_req_addr, mem_rsp_data;
    logic        redirect_valid, inst_valid, inst_ready, inst_fault;
    logic [31:0] redirect_pc, inst, inst_pc;

    fetch_unit #(.RESET_ADDR(RA), .DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_mem_req_valid  (mem_req_valid),
        .i_mem_req_ready  (mem_req_ready),
        .o_mem_req_addr   (mem_req_addr),
        .i_mem_rsp_valid  (mem_rsp_valid),
        .i_mem_rsp_data   (mem_rsp_data),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_inst_valid     (inst_valid),
        .i_inst_ready     (inst_ready),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
        .o_inst_fault     (inst_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        mq[$];
    logic [31:0] fq[$];
    logic [31:0] m_pc, m_fpc;
    bit          m_fault;
    int          total, bad, cyc, mr_pct, ir_pct, lat;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit red, input logic [31:0] tgt);
        bit   rsp, exp_rv, exp_iv, pop;
        req_t r;
        @(negedge clk);
        mem_req_ready  = $urandom_range(99) < mr_pct;
        inst_ready     = $urandom_range(99) < ir_pct;
        redirect_valid = red;
        redirect_pc    = tgt;
        rsp            = mq.size() > 0 && mq[0].due <= cyc;
        mem_rsp_valid  = rsp;
        mem_rsp_data   = rsp ? word(mq[0].addr) : $urandom;
        #1;
        exp_rv = !m_fault && !red && (fq.size() + mq.size() < DEPTH);
        exp_iv = m_fault || fq.size() > 0;
        chk("req_valid", 32'(mem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", mem_req_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
        chk("inst_fault", 32'(inst_fault), 32'(m_fault));
        if (exp_iv) begin
            chk("inst_pc", inst_pc, m_fault ? m_fpc : fq[0]);
            chk("inst", inst, m_fault ? 32'h0 : word(fq[0]));
        end
        pop = exp_iv && inst_ready && !m_fault && !red;
        if (pop) void'(fq.pop_front());
        if (rsp) begin
            r = mq.pop_front();
            if (!r.stale && !red) fq.push_back(r.addr);
        end
        if (exp_rv && mem_req_ready) begin
            r.addr  = m_pc;
            r.due   = cyc + lat;
            r.stale = 1'b0;
            mq.push_back(r);
            m_pc += 32'd4;
        end
        if (red) begin
            fq.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
            m_pc    = tgt;
            m_fpc   = tgt;
            m_fault = tgt[1:0] != 2'b00;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_req_addr", mem_req_addr, RA);
        chk("rst_inst_fault", 32'(inst_fault), 32'h0);
        mq.delete();
        fq.delete();
        m_pc    = RA;
        m_fpc   = RA;
        m_fault = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] t;
        total = 0; bad = 0; cyc = 0;
        rst_n = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        mr_pct = 100; ir_pct = 100; lat = 1;
        do_reset();
        repeat (20) cycle(1'b0, '0);
        ir_pct = 0;
        repeat (10) cycle(1'b0, '0);
        ir_pct = 100;
        repeat (10) cycle(1'b0, '0);
        lat = 3;
        repeat (4) cycle(1'b0, '0);
        cycle(1'b1, 32'h100);
        repeat (15) cycle(1'b0, '0);
        lat = 1;
        repeat (5) cycle(1'b0, '0);
        cycle(1'b1, 32'h180);
        repeat (5) cycle(1'b0, '0);
        cycle(1'b1, 32'h102);
        repeat (6) cycle(1'b0, '0);
        cycle(1'b1, 32'h200);
        repeat (10) cycle(1'b0, '0);
        cycle(1'b1, 32'hFFFF_FFF8);
        repeat (10) cycle(1'b0, '0);
        cycle(1'b1, 32'h300);
        cycle(1'b1, 32'h400);
        repeat (6) cycle(1'b0, '0);
        do_reset();
        repeat (8) cycle(1'b0, '0);
        for (int k = 0; k < 3000; k++) begin
            if (k % 250 == 0) begin
                lat    = $urandom_range(1, 4);
                mr_pct = $urandom_range(30, 100);
                ir_pct = $urandom_range(20, 100);
            end
            if (k % 1000 == 999) do_reset();
            t = $urandom;
            t[1:0] = ($urandom_range(9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle($urandom_range(99) < 5, t);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
